// File: rtl/race_draw_if.sv
// Command/status bundle between the race-game controller (master) and the
// drawing datapath (slave).
interface race_draw_if;
  // Commands are level-held one-hot selects; inc, step_left, step_right and
  // step_fwd are single-cycle strobes. There is no back-pressure: the datapath
  // acts on every cycle, and the controller paces itself off counterx/countery.
  logic       draw_bg_green_left;
  logic       draw_bg_black;
  logic       draw_bg_green_right;
  logic       draw_car;
  logic       erase;
  logic       update_car;
  logic       inc;
  logic       step_left;
  logic       step_right;
  logic       step_fwd;
  logic [7:0] counterx;
  logic [7:0] countery;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic [7:0] car_x;
  logic [6:0] car_y;
  logic [2:0] mode_dbg;

  modport master (
    output draw_bg_green_left, draw_bg_black, draw_bg_green_right, draw_car,
           erase, update_car, inc, step_left, step_right, step_fwd,
    input  counterx, countery, vga_x, vga_y, vga_colour, plot, car_x, car_y,
           mode_dbg
  );

  modport slave (
    input  draw_bg_green_left, draw_bg_black, draw_bg_green_right, draw_car,
           erase, update_car, inc, step_left, step_right, step_fwd,
    output counterx, countery, vga_x, vga_y, vga_colour, plot, car_x, car_y,
           mode_dbg
  );
endinterface

// File: rtl/race_draw_datapath.sv
// Race-game drawing datapath: scan counters, registered VGA pixel writes and
// the car position register. Define LANE_MARK_EN for a dashed road centre line.
module race_draw_datapath #(
  parameter int SCREEN_H = 120,
  parameter int GREEN_W  = 30,
  parameter int ROAD_W   = 100,
  parameter int CAR_W    = 4,
  parameter int CAR_H    = 12,
  parameter int STEP_X   = 10,
  parameter int STEP_Y   = 4,
  parameter int CAR_X0   = 78,
  parameter int CAR_Y0   = 100
) (
  input  logic        clock,
  input  logic        reset,
  race_draw_if.slave  bus
);

  typedef enum logic [2:0] {
    M_IDLE    = 3'd0,
    M_GREEN_L = 3'd1,
    M_BLACK   = 3'd2,
    M_GREEN_R = 3'd3,
    M_CAR     = 3'd4,
    M_UPDATE  = 3'd5,
    M_ERASE   = 3'd6
  } mode_t;

  mode_t      mode_q, mode_d;
  logic       active, mode_change, plot_d;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_col;
  logic [8:0] height;
  logic [7:0] car_x_d;
  logic [6:0] car_y_d;

  assign bus.mode_dbg = mode_q;

  always_ff @(posedge clock) begin
    if (reset) mode_q <= M_IDLE;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = M_IDLE;
    if      (bus.erase)               mode_d = M_ERASE;
    else if (bus.update_car)          mode_d = M_UPDATE;
    else if (bus.draw_car)            mode_d = M_CAR;
    else if (bus.draw_bg_black)       mode_d = M_BLACK;
    else if (bus.draw_bg_green_right) mode_d = M_GREEN_R;
    else if (bus.draw_bg_green_left)  mode_d = M_GREEN_L;
    active      = (mode_d != M_IDLE);
    mode_change = (mode_d != mode_q);
  end

  // Pixel address/colour for the current counter values; registered below.
  always_comb begin
    pix_x   = bus.counterx;
    pix_y   = bus.countery[6:0];
    pix_col = 3'b000;
    height  = 9'(SCREEN_H);
    case (mode_d)
      M_GREEN_L: pix_col = 3'b010;
      M_BLACK, M_ERASE: begin
        pix_x = 8'(GREEN_W) + bus.counterx;
`ifdef LANE_MARK_EN
        if (pix_x == 8'(GREEN_W + ROAD_W / 2) && !bus.countery[3]) pix_col = 3'b111;
`endif
      end
      M_GREEN_R: begin
        pix_x   = 8'(GREEN_W + ROAD_W) + bus.counterx;
        pix_col = 3'b010;
      end
      M_CAR, M_UPDATE: begin
        pix_x   = bus.car_x + bus.counterx;
        pix_y   = bus.car_y + bus.countery[6:0];
        pix_col = 3'b100;
        height  = 9'(CAR_H);
      end
      default: ;
    endcase
    plot_d = active && !mode_change && !bus.inc && ({1'b0, bus.countery} < height);
  end

  // Car motion; 9-bit compares keep the clamps free of wrap-around.
  always_comb begin
    car_x_d = bus.car_x;
    car_y_d = bus.car_y;
    if (bus.step_left && !bus.step_right) begin
      if ({1'b0, bus.car_x} < 9'(GREEN_W + STEP_X)) car_x_d = 8'(GREEN_W);
      else                                          car_x_d = bus.car_x - 8'(STEP_X);
    end else if (bus.step_right && !bus.step_left) begin
      if ({1'b0, bus.car_x} + 9'(STEP_X) > 9'(GREEN_W + ROAD_W - CAR_W))
        car_x_d = 8'(GREEN_W + ROAD_W - CAR_W);
      else
        car_x_d = bus.car_x + 8'(STEP_X);
    end
    if (bus.step_fwd) begin
      if (bus.car_y < 7'(STEP_Y)) car_y_d = 7'(SCREEN_H - CAR_H);
      else                        car_y_d = bus.car_y - 7'(STEP_Y);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.counterx   <= '0;
      bus.countery   <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.plot       <= 1'b0;
      bus.car_x      <= 8'(CAR_X0);
      bus.car_y      <= 7'(CAR_Y0);
    end else begin
      bus.plot <= plot_d;
      if (plot_d) begin
        bus.vga_x      <= pix_x;
        bus.vga_y      <= pix_y;
        bus.vga_colour <= pix_col;
      end
      if (mode_change) begin
        bus.counterx <= '0;
        bus.countery <= '0;
      end else if (active) begin
        if (bus.inc) begin
          bus.counterx <= '0;
          bus.countery <= bus.countery + 8'd1;
        end else begin
          bus.counterx <= bus.counterx + 8'd1;
        end
      end
      if (mode_d == M_IDLE) begin
        bus.car_x <= car_x_d;
        bus.car_y <= car_y_d;
      end
    end
  end

endmodule

// File: tb/tb_race_draw_datapath.sv
// Directed bench for race_draw_datapath: region sweeps against an expected
// pixel queue, a car-motion vector table, and reset corner cases.
module tb_race_draw_datapath;
  localparam int W = 18;

  typedef struct {
    logic sl;
    logic sr;
    logic sf;
    logic busy;
    int   ex;
    int   ey;
  } mvec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  race_draw_if bus();

  race_draw_datapath dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // sel: 0 idle, 1 green_l, 2 black, 3 green_r, 4 draw_car, 5 update, 6 erase, 7 erase+draw_car
  task automatic set_cmd(input int sel);
    bus.draw_bg_green_left  = (sel == 1);
    bus.draw_bg_black       = (sel == 2);
    bus.draw_bg_green_right = (sel == 3);
    bus.draw_car            = (sel == 4 || sel == 7);
    bus.update_car          = (sel == 5);
    bus.erase               = (sel == 6 || sel == 7);
  endtask

  function automatic logic [2:0] exp_colour(input int sel, input int x, input int r,
                                            input logic [2:0] col);
`ifdef LANE_MARK_EN
    if ((sel == 2 || sel == 6 || sel == 7) && x == 80 && (r % 16) < 8) return 3'b111;
`endif
    return col;
  endfunction

  task automatic sweep(input int sel, input int w, input int rows, input int x0,
                       input int y0, input logic [2:0] col, input string tag);
    int n;
    int plots;
    bit done;
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back({8'(x0 + c), 7'(y0 + r), exp_colour(sel, x0 + c, r, col)});
    n = 0; plots = 0; done = 0;
    bus.inc = 1'b0;
    set_cmd(sel);
    while (!done && n < (w + 2) * (rows + 2) + 10) begin
      tick();
      n++;
      if (bus.plot) begin
        plots++;
        got = {bus.vga_x, bus.vga_y, bus.vga_colour};
        check_val({tag, " queue_nonempty"}, int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val({tag, " pixel"}, int'(got), int'(e));
        end
      end
      if (bus.countery == 8'(rows)) done = 1;
      else bus.inc = (bus.counterx == 8'(w));
    end
    bus.inc = 1'b0;
    set_cmd(0);
    check_val({tag, " finished"}, int'(done), 1);
    check_val({tag, " plot_count"}, plots, w * rows);
    check_val({tag, " leftover"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) begin
      tick();
      check_val({tag, " idle_no_plot"}, int'(bus.plot), 0);
    end
  endtask

  task automatic pulse(input logic sl, input logic sr, input logic sf, input logic busy);
    bus.step_left  = sl;
    bus.step_right = sr;
    bus.step_fwd   = sf;
    set_cmd(busy ? 4 : 0);
    tick();
    bus.step_left  = 1'b0;
    bus.step_right = 1'b0;
    bus.step_fwd   = 1'b0;
    set_cmd(0);
  endtask

  mvec_t vecs[22];

  initial begin
    int n;
    vecs[0]  = '{1, 0, 0, 0,  68, 100};
    vecs[1]  = '{1, 0, 0, 0,  58, 100};
    vecs[2]  = '{1, 0, 0, 0,  48, 100};
    vecs[3]  = '{1, 0, 0, 0,  38, 100};
    vecs[4]  = '{1, 0, 0, 0,  30, 100};
    vecs[5]  = '{1, 0, 0, 0,  30, 100};
    vecs[6]  = '{1, 1, 0, 0,  30, 100};
    vecs[7]  = '{0, 1, 0, 1,  30, 100};
    vecs[8]  = '{0, 1, 0, 0,  40, 100};
    vecs[9]  = '{0, 1, 0, 0,  50, 100};
    vecs[10] = '{0, 1, 0, 0,  60, 100};
    vecs[11] = '{0, 1, 0, 0,  70, 100};
    vecs[12] = '{0, 1, 0, 0,  80, 100};
    vecs[13] = '{0, 1, 0, 0,  90, 100};
    vecs[14] = '{0, 1, 0, 0, 100, 100};
    vecs[15] = '{0, 1, 0, 0, 110, 100};
    vecs[16] = '{0, 1, 0, 0, 120, 100};
    vecs[17] = '{0, 1, 0, 0, 126, 100};
    vecs[18] = '{0, 1, 0, 0, 126, 100};
    vecs[19] = '{1, 0, 1, 0, 116,  96};
    vecs[20] = '{1, 1, 1, 0, 116,  92};
    vecs[21] = '{0, 0, 1, 1, 116,  92};

    set_cmd(0);
    bus.inc = 1'b0;
    bus.step_left = 1'b0;
    bus.step_right = 1'b0;
    bus.step_fwd = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_val("rst counterx", bus.counterx, 0);
    check_val("rst countery", bus.countery, 0);
    check_val("rst vga_x", bus.vga_x, 0);
    check_val("rst vga_y", bus.vga_y, 0);
    check_val("rst colour", bus.vga_colour, 0);
    check_val("rst plot", bus.plot, 0);
    check_val("rst car_x", bus.car_x, 78);
    check_val("rst car_y", bus.car_y, 100);
    check_val("rst mode", bus.mode_dbg, 0);

    sweep(1, 30, 120, 0, 0, 3'b010, "green_left");
    sweep(2, 100, 120, 30, 0, 3'b000, "black");
    sweep(3, 30, 2, 130, 0, 3'b010, "green_right");
    sweep(7, 100, 1, 30, 0, 3'b000, "erase_prio");
    sweep(4, 4, 12, 78, 100, 3'b100, "draw_car");
    sweep(5, 4, 2, 78, 100, 3'b100, "update_car");

    foreach (vecs[i]) begin
      pulse(vecs[i].sl, vecs[i].sr, vecs[i].sf, vecs[i].busy);
      check_val($sformatf("move[%0d] car_x", i), bus.car_x, vecs[i].ex);
      check_val($sformatf("move[%0d] car_y", i), bus.car_y, vecs[i].ey);
    end

    repeat (22) pulse(0, 0, 1, 0);
    check_val("fwd to 4", bus.car_y, 4);
    pulse(0, 0, 1, 0);
    check_val("fwd to 0", bus.car_y, 0);
    pulse(0, 0, 1, 0);
    check_val("fwd wrap", bus.car_y, 108);
    pulse(0, 0, 1, 0);
    check_val("fwd after wrap", bus.car_y, 104);

    // Abort a black sweep at row 50 with reset.
    set_cmd(2);
    n = 0;
    while (bus.countery != 8'd50 && n < 6000) begin
      tick();
      n++;
      bus.inc = (bus.counterx == 8'd100);
    end
    check_val("mid reached row 50", bus.countery, 50);
    bus.inc = 1'b0;
    reset = 1'b1;
    tick();
    check_val("mid rst plot", bus.plot, 0);
    check_val("mid rst counterx", bus.counterx, 0);
    check_val("mid rst countery", bus.countery, 0);
    check_val("mid rst car_x", bus.car_x, 78);
    check_val("mid rst car_y", bus.car_y, 100);
    check_val("mid rst mode", bus.mode_dbg, 0);
    reset = 1'b0;
    set_cmd(0);
    repeat (3) begin
      tick();
      check_val("mid rst no_plot", bus.plot, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
